data_memory_param: RTL

DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

---
 rtl/data_memory_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/data_memory_param.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_param
// Description : Single-port word memory with self-zeroing INIT sweep,
//               1-cycle registered reads, range checking and a clear request.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  // Index width of the implemented array; at least one bit so DEPTH=1 still builds.
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DEPTH - 1);

  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_IDLE = 1'b1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [0:0]         r_state;
  logic [c_IDX_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;
  logic               r_err;

  logic               w_ready;
  logic               w_accept;
  logic               w_addr_ok;
  logic [c_IDX_W-1:0] w_idx;

  // Address compared at 32 bits so DEPTH == 2**ADDR_W is representable.
  assign w_addr_ok = ({{(32-ADDR_W){1'b0}}, addr} < 32'(DEPTH));
  // Low index bits only; aliasing for out-of-range addresses is masked by w_addr_ok.
  assign w_idx     = addr[c_IDX_W-1:0];
  assign w_ready   = (r_state == c_ST_IDLE);
  // clr wins over a simultaneous request.
  assign w_accept  = req & w_ready & ~clr;

  assign ready  = w_ready;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;

  // Array storage: never reset; zeroed word-by-word during INIT, else written by accepted in-range writes.
  always_ff @(posedge clk) begin
    if (r_state == c_ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_accept && we && w_addr_ok) begin
      r_mem[w_idx] <= wdata;
    end
  end

  // Sweep FSM: INIT counts through every word, IDLE serves accesses until clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          if (r_cnt == c_LAST) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (clr) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Response registers: rvalid/err pulse one cycle after an accepted access, rdata holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_accept & ~we;
      r_err    <= w_accept & ~w_addr_ok;
      if (w_accept && !we) begin
        r_rdata <= w_addr_ok ? r_mem[w_idx] : '0;
      end
    end
  end

endmodule
`default_nettype wire
